// File: rtl/uart_loader_ctrl.sv
// uart_loader_ctrl: byte-oriented host command sequencer sitting between the
// UART rx/tx FIFOs and the CPU subsystem. It parses load/run/halt commands,
// assembles little-endian instruction words, writes them into instruction
// memory, gates the CPU run enable and answers every command with ACK/NAK.
module uart_loader_ctrl #(
    parameter int NB_INSTRUCTION  = 32,
    parameter int IMEM_ADDR_WIDTH = 10,
    parameter int NB_UART_DATA    = 8,
    parameter int NB_TIMEOUT      = 24,
    parameter int TIMEOUT_CYC     = 5_000_000
) (
    input  logic                       clk,
    input  logic                       i_rst_n,
    input  logic [NB_UART_DATA-1:0]    i_uart_rdata,
    input  logic                       i_rx_empty,
    input  logic                       i_tx_full,
    input  logic                       i_tx_done,
    input  logic                       i_locked,
    output logic                       o_uart_rd,
    output logic                       o_uart_wr,
    output logic [NB_UART_DATA-1:0]    o_uart_wdata,
    output logic                       o_uart_tx_start,
    output logic                       o_imem_we,
    output logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr,
    output logic [NB_INSTRUCTION-1:0]  o_imem_wdata,
    output logic                       o_cpu_en,
    output logic                       o_cpu_flush,
    output logic                       o_busy
);

    // Command and reply byte values.
    localparam logic [NB_UART_DATA-1:0] CMD_LOAD_C = 8'h4C;
    localparam logic [NB_UART_DATA-1:0] CMD_RUN_C  = 8'h52;
    localparam logic [NB_UART_DATA-1:0] CMD_HALT_C = 8'h48;
    localparam logic [NB_UART_DATA-1:0] ACK_C      = 8'h06;
    localparam logic [NB_UART_DATA-1:0] NAK_C      = 8'h15;

    // Largest accepted word count is the full memory depth.
    localparam logic [16:0] MAX_WORDS_C = 17'd1 << IMEM_ADDR_WIDTH;

    // Timeout fires on the TIMEOUT_CYC-th consecutive empty wait cycle.
    localparam logic [NB_TIMEOUT-1:0] TMO_LAST_C = NB_TIMEOUT'(TIMEOUT_CYC - 32'sd1);
    localparam logic [NB_TIMEOUT-1:0] TMO_ONE_C  = {{(NB_TIMEOUT-1){1'b0}}, 1'b1};
    localparam logic [NB_TIMEOUT-1:0] TMO_ZERO_C = {NB_TIMEOUT{1'b0}};

    localparam logic [IMEM_ADDR_WIDTH-1:0] IDX_ONE_C  = {{(IMEM_ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [IMEM_ADDR_WIDTH-1:0] IDX_ZERO_C = {IMEM_ADDR_WIDTH{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_WRITE,
        ST_SEND,
        ST_KICK,
        ST_WAIT_TX
    } state_t;

    // Registered state.
    state_t                      state_r;
    logic                        rd_r;
    logic                        wr_r;
    logic [NB_UART_DATA-1:0]     wdata_r;
    logic                        tx_start_r;
    logic                        we_r;
    logic [IMEM_ADDR_WIDTH-1:0]  addr_r;
    logic [NB_INSTRUCTION-1:0]   imem_wdata_r;
    logic                        flush_r;
    logic                        busy_r;
    logic                        run_flag_r;
    logic [15:0]                 len_r;
    logic [NB_INSTRUCTION-1:0]   word_r;
    logic [IMEM_ADDR_WIDTH-1:0]  word_idx_r;
    logic [1:0]                  byte_cnt_r;
    logic [NB_TIMEOUT-1:0]       tmo_cnt_r;
    logic [NB_UART_DATA-1:0]     reply_r;

    // Next-state values.
    state_t                      state_s;
    logic                        rd_s;
    logic                        wr_s;
    logic [NB_UART_DATA-1:0]     wdata_s;
    logic                        tx_start_s;
    logic                        we_s;
    logic [IMEM_ADDR_WIDTH-1:0]  addr_s;
    logic [NB_INSTRUCTION-1:0]   imem_wdata_s;
    logic                        flush_s;
    logic                        busy_s;
    logic                        run_flag_s;
    logic [15:0]                 len_s;
    logic [NB_INSTRUCTION-1:0]   word_s;
    logic [IMEM_ADDR_WIDTH-1:0]  word_idx_s;
    logic [1:0]                  byte_cnt_s;
    logic [NB_TIMEOUT-1:0]       tmo_cnt_s;
    logic [NB_UART_DATA-1:0]     reply_s;

    // Word count as it would be once the high length byte is taken.
    logic [15:0]                 len_full_s;
    logic                        len_bad_s;
    logic                        last_word_s;

    assign len_full_s  = {i_uart_rdata, len_r[7:0]};
    assign len_bad_s   = (len_full_s == 16'd0) || ({1'b0, len_full_s} > MAX_WORDS_C);
    assign last_word_s = (16'(word_idx_r) == (len_r - 16'd1));

    // State and datapath registers; reset clears everything, aborting any load.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r      <= ST_IDLE;
            rd_r         <= 1'b0;
            wr_r         <= 1'b0;
            wdata_r      <= {NB_UART_DATA{1'b0}};
            tx_start_r   <= 1'b0;
            we_r         <= 1'b0;
            addr_r       <= IDX_ZERO_C;
            imem_wdata_r <= {NB_INSTRUCTION{1'b0}};
            flush_r      <= 1'b0;
            busy_r       <= 1'b0;
            run_flag_r   <= 1'b0;
            len_r        <= 16'd0;
            word_r       <= {NB_INSTRUCTION{1'b0}};
            word_idx_r   <= IDX_ZERO_C;
            byte_cnt_r   <= 2'd0;
            tmo_cnt_r    <= TMO_ZERO_C;
            reply_r      <= {NB_UART_DATA{1'b0}};
        end else begin
            state_r      <= state_s;
            rd_r         <= rd_s;
            wr_r         <= wr_s;
            wdata_r      <= wdata_s;
            tx_start_r   <= tx_start_s;
            we_r         <= we_s;
            addr_r       <= addr_s;
            imem_wdata_r <= imem_wdata_s;
            flush_r      <= flush_s;
            busy_r       <= busy_s;
            run_flag_r   <= run_flag_s;
            len_r        <= len_s;
            word_r       <= word_s;
            word_idx_r   <= word_idx_s;
            byte_cnt_r   <= byte_cnt_s;
            tmo_cnt_r    <= tmo_cnt_s;
            reply_r      <= reply_s;
        end
    end

    // Next-state and output decode. A pop is requested one cycle (rd_s) and
    // the byte is consumed in the following cycle while rd_r is high, which
    // also enforces the idle gap between consecutive pops.
    always_comb begin
        state_s      = state_r;
        rd_s         = 1'b0;
        wr_s         = 1'b0;
        wdata_s      = wdata_r;
        tx_start_s   = 1'b0;
        we_s         = 1'b0;
        addr_s       = addr_r;
        imem_wdata_s = imem_wdata_r;
        flush_s      = 1'b0;
        run_flag_s   = run_flag_r;
        len_s        = len_r;
        word_s       = word_r;
        word_idx_s   = word_idx_r;
        byte_cnt_s   = byte_cnt_r;
        tmo_cnt_s    = tmo_cnt_r;
        reply_s      = reply_r;

        case (state_r)
            ST_IDLE: begin
                tmo_cnt_s = TMO_ZERO_C;
                if (rd_r) begin
                    case (i_uart_rdata)
                        CMD_LOAD_C: begin
                            run_flag_s = 1'b0;
                            flush_s    = 1'b1;
                            word_idx_s = IDX_ZERO_C;
                            byte_cnt_s = 2'd0;
                            state_s    = ST_LEN0;
                        end
                        CMD_RUN_C: begin
                            run_flag_s = 1'b1;
                            flush_s    = 1'b1;
                            reply_s    = ACK_C;
                            state_s    = ST_SEND;
                        end
                        CMD_HALT_C: begin
                            run_flag_s = 1'b0;
                            reply_s    = ACK_C;
                            state_s    = ST_SEND;
                        end
                        default: begin
                            reply_s = NAK_C;
                            state_s = ST_SEND;
                        end
                    endcase
                end else if (!i_rx_empty) begin
                    rd_s = 1'b1;
                end else begin
                    rd_s = 1'b0;
                end
            end

            ST_LEN0: begin
                if (rd_r) begin
                    len_s     = {len_r[15:8], i_uart_rdata};
                    tmo_cnt_s = TMO_ZERO_C;
                    state_s   = ST_LEN1;
                end else if (!i_rx_empty) begin
                    rd_s = 1'b1;
                end else if (tmo_cnt_r == TMO_LAST_C) begin
                    tmo_cnt_s = TMO_ZERO_C;
                    reply_s   = NAK_C;
                    state_s   = ST_SEND;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + TMO_ONE_C;
                end
            end

            ST_LEN1: begin
                if (rd_r) begin
                    tmo_cnt_s = TMO_ZERO_C;
                    if (len_bad_s) begin
                        reply_s = NAK_C;
                        state_s = ST_SEND;
                    end else begin
                        len_s      = len_full_s;
                        byte_cnt_s = 2'd0;
                        state_s    = ST_DATA;
                    end
                end else if (!i_rx_empty) begin
                    rd_s = 1'b1;
                end else if (tmo_cnt_r == TMO_LAST_C) begin
                    tmo_cnt_s = TMO_ZERO_C;
                    reply_s   = NAK_C;
                    state_s   = ST_SEND;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + TMO_ONE_C;
                end
            end

            ST_DATA: begin
                if (rd_r) begin
                    // Little-endian: the first byte ends up in the low lane.
                    word_s     = {i_uart_rdata, word_r[NB_INSTRUCTION-1:NB_UART_DATA]};
                    byte_cnt_s = byte_cnt_r + 2'd1;
                    tmo_cnt_s  = TMO_ZERO_C;
                    if (byte_cnt_r == 2'd3) begin
                        state_s = ST_WRITE;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else if (!i_rx_empty) begin
                    rd_s = 1'b1;
                end else if (tmo_cnt_r == TMO_LAST_C) begin
                    tmo_cnt_s = TMO_ZERO_C;
                    reply_s   = NAK_C;
                    state_s   = ST_SEND;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + TMO_ONE_C;
                end
            end

            ST_WRITE: begin
                we_s         = 1'b1;
                addr_s       = word_idx_r;
                imem_wdata_s = word_r;
                word_idx_s   = word_idx_r + IDX_ONE_C;
                if (last_word_s) begin
                    reply_s = ACK_C;
                    state_s = ST_SEND;
                end else begin
                    state_s = ST_DATA;
                end
            end

            ST_SEND: begin
                if (!i_tx_full) begin
                    wr_s    = 1'b1;
                    wdata_s = reply_r;
                    state_s = ST_KICK;
                end else begin
                    state_s = ST_SEND;
                end
            end

            ST_KICK: begin
                tx_start_s = 1'b1;
                state_s    = ST_WAIT_TX;
            end

            ST_WAIT_TX: begin
                if (i_tx_done) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT_TX;
                end
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    assign o_uart_rd       = rd_r;
    assign o_uart_wr       = wr_r;
    assign o_uart_wdata    = wdata_r;
    assign o_uart_tx_start = tx_start_r;
    assign o_imem_we       = we_r;
    assign o_imem_addr     = addr_r;
    assign o_imem_wdata    = imem_wdata_r;
    assign o_cpu_flush     = flush_r;
    assign o_busy          = busy_r;
    // Lock loss gates the CPU off immediately without forgetting run_flag.
    assign o_cpu_en        = run_flag_r & i_locked;

endmodule
